// File: rtl/uart_tx_stage.sv
//-----------------------------------------------------------------------------
// uart_tx_stage
//
// 8N1 UART transmitter feeding the UART_TX PMOD pin. Bytes arrive over a
// valid/ready handshake and are sent LSB first: one low start bit, eight data
// bits, and one high stop bit. Each bit lasts CLKS_PER_BIT cycles. The line
// idles high.
//
// Ports:
//   clk    in   1  system clock; all state changes on its rising edge
//   rst    in   1  asynchronous, active-high reset
//   data   in   8  byte to send; sampled only on the acceptance edge
//   valid  in   1  upstream has a byte on data
//   ready  out  1  registered; high while the block can accept a byte
//   tx     out  1  registered serial line
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_stage #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    // A one-cycle bit would leave no room for the counter to wrap.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx_stage: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       idx_r;
    logic [7:0]       shift_r;
    logic             bit_done_s;

    // Last cycle of the current bit period.
    assign bit_done_s = (cnt_r == CNT_LAST);

    // Transmit FSM; tx and ready are driven straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            tx      <= 1'b1;
            ready   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    idx_r <= 3'd0;
                    // ready is a flop, so the first edge after reset only
                    // raises it; acceptance needs it already high.
                    if (valid && ready) begin
                        shift_r <= data;
                        state_r <= START;
                        tx      <= 1'b0;
                        ready   <= 1'b0;
                    end else begin
                        tx      <= 1'b1;
                        ready   <= 1'b1;
                    end
                end
                START: begin
                    ready <= 1'b0;
                    if (bit_done_s) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        idx_r   <= 3'd0;
                        state_r <= DATA;
                        tx      <= shift_r[0];
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        tx      <= 1'b0;
                    end
                end
                DATA: begin
                    ready <= 1'b0;
                    if (bit_done_s) begin
                        cnt_r <= {CNT_W{1'b0}};
                        // Index stops at 7; the stop bit follows, never a 9th bit.
                        if (idx_r == 3'd7) begin
                            state_r <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            idx_r   <= idx_r + 3'd1;
                            tx      <= shift_r[idx_r + 3'd1];
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_done_s) begin
                        // ready rises on the last stop edge so a held valid is
                        // taken one edge later: frames are 10*CPB+1 apart.
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= IDLE;
                        ready   <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                    idx_r   <= 3'd0;
                    tx      <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
